wake_up_scheduler: RTL and testbench



---
 rtl/wake_up_scheduler.sv | 151 +++++++++++++++
 tb/tb_wake_up_scheduler.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/wake_up_scheduler.sv
// Merges per-requester core wake-up masks and releases them one batch per issue, GapCycles idle between batches.
// Latency 2 cycles request->first batch; no backpressure, repeated requests for a pending core collapse into one pulse.
// WAKE_UP_SCHED_BROADCAST_EN: an all-ones request mask wakes every core on the next cycle, bypassing batching.
module wake_up_scheduler #(
    parameter int unsigned NumCores      = 256,
    parameter int unsigned NumRequesters = 2,
    parameter int unsigned BatchSize     = 16,
    parameter int unsigned GapCycles     = 4
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic [NumRequesters-1:0]                req_valid_i,
    input  logic [NumRequesters-1:0][NumCores-1:0]  req_mask_i,
    input  logic                                    flush_i,
    output logic [NumCores-1:0]                     wake_up_o,
    output logic                                    busy_o
);
    localparam int unsigned NumBatches = NumCores / BatchSize;
    localparam int unsigned PtrW       = (NumBatches > 1) ? $clog2(NumBatches) : 1;
    localparam logic [7:0]  GapInit    = 8'(GapCycles);

    typedef enum logic {ST_IDLE, ST_GAP} state_e;

    state_e              state_q, state_d;
    logic [NumCores-1:0] pend_q, pend_d;
    logic [NumCores-1:0] wake_q, wake_d;
    logic [PtrW-1:0]     ptr_q, ptr_d;
    logic [7:0]          cnt_q, cnt_d;

    logic [NumCores-1:0]   req_or;
    logic [NumBatches-1:0] batch_nz;
    logic                  sel_found;
    logic [PtrW-1:0]       sel_idx, sel_nxt;
    logic [PtrW:0]         cand;
    logic [NumCores-1:0]   issue_mask, issued;
`ifdef WAKE_UP_SCHED_BROADCAST_EN
    logic                  bcast;
`endif

    always_comb begin
        req_or = '0;
`ifdef WAKE_UP_SCHED_BROADCAST_EN
        bcast  = 1'b0;
`endif
        for (int r = 0; r < NumRequesters; r++) begin
            if (req_valid_i[r]) begin
                req_or = req_or | req_mask_i[r];
`ifdef WAKE_UP_SCHED_BROADCAST_EN
                bcast  = bcast | (&req_mask_i[r]);
`endif
            end
        end
    end

    always_comb begin
        for (int b = 0; b < NumBatches; b++) begin
            batch_nz[b] = |pend_q[b*BatchSize +: BatchSize];
        end
    end

    // First non-empty batch scanning round-robin from ptr_q.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NumBatches; i++) begin
            cand = {1'b0, ptr_q} + (PtrW+1)'(i);
            if (cand >= (PtrW+1)'(NumBatches)) begin
                cand = cand - (PtrW+1)'(NumBatches);
            end
            if (!sel_found && batch_nz[cand[PtrW-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[PtrW-1:0];
            end
        end
        sel_nxt = (sel_idx == PtrW'(NumBatches - 1)) ? '0 : sel_idx + 1'b1;
    end

    always_comb begin
        issue_mask = '0;
        for (int b = 0; b < NumBatches; b++) begin
            if (sel_idx == PtrW'(b)) begin
                issue_mask[b*BatchSize +: BatchSize] = pend_q[b*BatchSize +: BatchSize];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        wake_d  = '0;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        issued  = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (sel_found) begin
                    issued  = issue_mask;
                    wake_d  = issue_mask;
                    ptr_d   = sel_nxt;
                    cnt_d   = GapInit;
                    state_d = (GapCycles == 0) ? ST_IDLE : ST_GAP;
                end
            end
            ST_GAP: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A core issued and re-requested on the same edge stays pending.
        pend_d = (pend_q & ~issued) | req_or;
`ifdef WAKE_UP_SCHED_BROADCAST_EN
        if (bcast) begin
            wake_d  = '1;
            pend_d  = '0;
            ptr_d   = ptr_q;
            cnt_d   = GapInit;
            state_d = (GapCycles == 0) ? ST_IDLE : ST_GAP;
        end
`endif
        if (flush_i) begin
            pend_d  = '0;
            wake_d  = '0;
            ptr_d   = ptr_q;
            cnt_d   = '0;
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
            wake_q  <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            wake_q  <= wake_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign wake_up_o = wake_q;
    assign busy_o    = (pend_q != '0) | (state_q == ST_GAP);

endmodule

// File: tb/tb_wake_up_scheduler.sv
// Scoreboard bench for wake_up_scheduler: expected pulses are queued by the stimulus, a monitor compares them.
module tb_wake_up_scheduler;
    localparam int NC = 256;

    logic                clk       = 1'b0;
    logic                rst       = 1'b1;
    logic [1:0]          req_valid = '0;
    logic [1:0][NC-1:0]  req_mask  = '0;
    logic                flush     = 1'b0;
    logic [NC-1:0]       wake_up;
    logic                busy;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    typedef struct {
        int            cyc;
        logic [NC-1:0] mask;
    } exp_t;
    exp_t exp_q[$];

    wake_up_scheduler #(
        .NumCores(256), .NumRequesters(2), .BatchSize(16), .GapCycles(4)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_valid_i(req_valid),
        .req_mask_i (req_mask),
        .flush_i    (flush),
        .wake_up_o  (wake_up),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [NC-1:0] onehot(input int b);
        logic [NC-1:0] m;
        m    = '0;
        m[b] = 1'b1;
        return m;
    endfunction

    function automatic logic [NC-1:0] batch_m(input int b);
        logic [NC-1:0] m;
        m = '0;
        m[b*16 +: 16] = '1;
        return m;
    endfunction

    task automatic chk(input string name, input logic [NC-1:0] got, input logic [NC-1:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, got, req);
        end
    endtask

    task automatic expect_pulse(input int c, input logic [NC-1:0] m);
        exp_t e;
        e.cyc  = c;
        e.mask = m;
        exp_q.push_back(e);
    endtask

    task automatic clear_req();
        req_valid = '0;
        req_mask  = '0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(name, NC'(busy), '0);
        repeat (2) @(negedge clk);
    endtask

    // Monitor: every non-zero wake-up vector must match the head of the queue.
    always @(negedge clk) begin
        if (wake_up !== '0) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse: cycle %0d got %0h required none", cyc, wake_up);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("pulse_cycle", NC'(cyc), NC'(e.cyc));
                chk("pulse_mask", wake_up, e.mask);
            end
        end
    end

    initial begin
        int c;

        // Reset held with requests active.
        @(negedge clk);
        req_valid   = 2'b11;
        req_mask[0] = '1;
        req_mask[1] = onehot(9);
        for (int i = 0; i < 3; i++) begin
            chk("reset_wake", wake_up, '0);
            chk("reset_busy", NC'(busy), '0);
            @(negedge clk);
        end
        rst = 1'b0;
        clear_req();
        @(negedge clk);
        chk("post_reset_wake", wake_up, '0);
        chk("post_reset_busy", NC'(busy), '0);

        // Stagger and merge from ptr=0.
        c = cyc;
        req_valid   = 2'b11;
        req_mask[0] = onehot(0);
        req_mask[1] = onehot(200);
        expect_pulse(c + 2, onehot(0));
        expect_pulse(c + 7, onehot(200));
        @(negedge clk);
        clear_req();
        wait_idle("t3_idle");

        // Round robin from ptr=13: batch 15 before batch 0.
        c = cyc;
        req_valid   = 2'b11;
        req_mask[0] = onehot(5);
        req_mask[1] = onehot(250);
        expect_pulse(c + 2, onehot(250));
        expect_pulse(c + 7, onehot(5));
        @(negedge clk);
        clear_req();
        wait_idle("t4_idle");

        // Single core, busy window.
        c = cyc;
        req_valid   = 2'b01;
        req_mask[0] = onehot(37);
        expect_pulse(c + 2, onehot(37));
        @(negedge clk);
        clear_req();
        for (int k = 1; k <= 6; k++) begin
            chk("t2_busy", NC'(busy), NC'(k <= 5));
            @(negedge clk);
        end
        wait_idle("t2_idle");

        // Re-request on the issuing edge gives a second pulse 5 cycles later.
        c = cyc;
        req_valid   = 2'b01;
        req_mask[0] = onehot(37);
        expect_pulse(c + 2, onehot(37));
        expect_pulse(c + 7, onehot(37));
        @(negedge clk);
        req_valid   = 2'b10;
        req_mask[0] = '0;
        req_mask[1] = onehot(37);
        @(negedge clk);
        clear_req();
        wait_idle("t5a_idle");

        // Reset mid-gap discards the remaining pending core.
        c = cyc;
        req_valid   = 2'b01;
        req_mask[0] = onehot(100) | onehot(255);
        expect_pulse(c + 2, onehot(100));
        @(negedge clk);
        clear_req();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_reset_busy", NC'(busy), '0);
        chk("mid_reset_wake", wake_up, '0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("after_reset_busy", NC'(busy), '0);

        // Flush after bit 0 issues; a request in the flush cycle is dropped too.
        c = cyc;
        req_valid   = 2'b11;
        req_mask[0] = onehot(0);
        req_mask[1] = onehot(255);
        expect_pulse(c + 2, onehot(0));
        @(negedge clk);
        clear_req();
        @(negedge clk);
        flush       = 1'b1;
        req_valid   = 2'b01;
        req_mask[0] = onehot(3);
        @(negedge clk);
        flush = 1'b0;
        clear_req();
        chk("flush_busy", NC'(busy), '0);
        chk("flush_wake", wake_up, '0);
        repeat (40) @(negedge clk);
        chk("flush_busy_later", NC'(busy), '0);

        // All-ones mask; ptr is 1 here.
        c = cyc;
        req_valid   = 2'b01;
        req_mask[0] = '1;
`ifdef WAKE_UP_SCHED_BROADCAST_EN
        expect_pulse(c + 1, '1);
`else
        for (int k = 0; k < 16; k++) begin
            expect_pulse(c + 2 + 5 * k, batch_m((1 + k) % 16));
        end
`endif
        @(negedge clk);
        clear_req();
        wait_idle("t6_idle");

        repeat (10) @(negedge clk);
        chk("queue_drained", NC'(exp_q.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
